// File: rtl/agc_prefix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : agc_prefix_sequencer
// Brief    : Absorbs EXTEND/INDEX prefixes between fetch and decode, fetches
//            INDEX operands and hands the effective word to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module agc_prefix_sequencer #(
    parameter int WORD_W      = 15,
    parameter int ADDR_W      = 12,
    parameter int MAX_CHAIN   = 4,
    parameter int ONES_COMP   = 1,
    parameter int EXTEND_CODE = 'o00006
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              flush,
    input  logic              instr_valid,
    input  logic [WORD_W-1:0] instr,
    output logic              instr_ready,
    output logic              idx_req_valid,
    output logic [ADDR_W-1:0] idx_req_addr,
    input  logic              idx_rsp_valid,
    input  logic [WORD_W-1:0] idx_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [WORD_W-1:0] dec_word,
    output logic              dec_ext,
    output logic              int_inhibit,
    output logic              illegal
);

    localparam int c_CNT_W = $clog2(MAX_CHAIN + 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_IDX = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_ext;
    logic [WORD_W-1:0]   r_idx_acc;
    logic [c_CNT_W-1:0]  r_chain_cnt;
    logic                r_dec_valid;
    logic [WORD_W-1:0]   r_dec_word;
    logic                r_dec_ext;
    logic                r_idx_req_valid;
    logic [ADDR_W-1:0]   r_idx_req_addr;
    logic                r_illegal;

    logic                w_ext_nxt;
    logic [WORD_W-1:0]   w_idx_acc_nxt;
    logic [c_CNT_W-1:0]  w_chain_cnt_nxt;
    logic                w_dec_valid_nxt;
    logic [WORD_W-1:0]   w_dec_word_nxt;
    logic                w_dec_ext_nxt;
    logic                w_idx_req_valid_nxt;
    logic [ADDR_W-1:0]   w_idx_req_addr_nxt;
    logic                w_illegal_nxt;

    logic [WORD_W-1:0]   w_eff;
    logic                w_accept;
    logic                w_is_extend;
    logic                w_is_index;
    logic                w_chain_full;

    // Effective word: accumulated index added to the fetched word.
    generate
        if (ONES_COMP != 0) begin : g_ones_comp
            logic [WORD_W:0] w_sum;
            assign w_sum = {1'b0, r_idx_acc} + {1'b0, instr};
            // End-around carry cannot overflow again: max low part is 2^W-2.
            assign w_eff = w_sum[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, w_sum[WORD_W]};
        end else begin : g_binary
            assign w_eff = r_idx_acc + instr;
        end
    endgenerate

    assign instr_ready  = (r_state == ST_IDLE) && (!r_dec_valid || dec_ready) && !flush;
    assign w_accept     = instr_valid && instr_ready;
    assign w_is_extend  = (w_eff == WORD_W'(EXTEND_CODE));
    assign w_is_index   = (w_eff[WORD_W-1 -: 3] == 3'o5) &&
                          (r_ext || (w_eff[ADDR_W-1 -: 2] == 2'b00));
    assign w_chain_full = (r_chain_cnt == c_CNT_W'(MAX_CHAIN));

    always_comb begin
        w_state_nxt         = r_state;
        w_ext_nxt           = r_ext;
        w_idx_acc_nxt       = r_idx_acc;
        w_chain_cnt_nxt     = r_chain_cnt;
        w_dec_valid_nxt     = r_dec_valid && !dec_ready;
        w_dec_word_nxt      = r_dec_word;
        w_dec_ext_nxt       = r_dec_ext;
        w_idx_req_valid_nxt = r_idx_req_valid;
        w_idx_req_addr_nxt  = r_idx_req_addr;
        w_illegal_nxt       = 1'b0;

        if (flush) begin
            w_state_nxt         = ST_IDLE;
            w_ext_nxt           = 1'b0;
            w_idx_acc_nxt       = '0;
            w_chain_cnt_nxt     = '0;
            w_dec_valid_nxt     = 1'b0;
            w_idx_req_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_extend) begin
                            w_ext_nxt = 1'b1;
                            if (!r_ext) begin
                                w_idx_acc_nxt = '0;
                            end
                        end else if (w_is_index) begin
                            if (!w_chain_full) begin
                                w_chain_cnt_nxt     = r_chain_cnt + c_CNT_W'(1);
                                w_idx_req_addr_nxt  = w_eff[ADDR_W-1:0];
                                w_idx_req_valid_nxt = 1'b1;
                                w_state_nxt         = ST_WAIT_IDX;
                            end else begin
                                w_illegal_nxt   = 1'b1;
                                w_ext_nxt       = 1'b0;
                                w_idx_acc_nxt   = '0;
                                w_chain_cnt_nxt = '0;
                            end
                        end else begin
                            w_dec_word_nxt  = w_eff;
                            w_dec_ext_nxt   = r_ext;
                            w_dec_valid_nxt = 1'b1;
                            w_ext_nxt       = 1'b0;
                            w_idx_acc_nxt   = '0;
                            w_chain_cnt_nxt = '0;
                        end
                    end
                end
                ST_WAIT_IDX: begin
                    // Response replaces the accumulator; prior index is already in the address.
                    if (idx_rsp_valid) begin
                        w_idx_acc_nxt       = idx_rsp_data;
                        w_idx_req_valid_nxt = 1'b0;
                        w_state_nxt         = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_ext           <= 1'b0;
            r_idx_acc       <= '0;
            r_chain_cnt     <= '0;
            r_dec_valid     <= 1'b0;
            r_dec_word      <= '0;
            r_dec_ext       <= 1'b0;
            r_idx_req_valid <= 1'b0;
            r_idx_req_addr  <= '0;
            r_illegal       <= 1'b0;
        end else begin
            r_ext           <= w_ext_nxt;
            r_idx_acc       <= w_idx_acc_nxt;
            r_chain_cnt     <= w_chain_cnt_nxt;
            r_dec_valid     <= w_dec_valid_nxt;
            r_dec_word      <= w_dec_word_nxt;
            r_dec_ext       <= w_dec_ext_nxt;
            r_idx_req_valid <= w_idx_req_valid_nxt;
            r_idx_req_addr  <= w_idx_req_addr_nxt;
            r_illegal       <= w_illegal_nxt;
        end
    end

    assign idx_req_valid = r_idx_req_valid;
    assign idx_req_addr  = r_idx_req_addr;
    assign dec_valid     = r_dec_valid;
    assign dec_word      = r_dec_word;
    assign dec_ext       = r_dec_ext;
    assign illegal       = r_illegal;
    assign int_inhibit   = r_ext || (r_chain_cnt != '0) || (r_state == ST_WAIT_IDX);

endmodule
`default_nettype wire

// File: tb/tb_agc_prefix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_prefix_sequencer
// Brief    : Directed plus randomized bench against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agc_prefix_sequencer;

    localparam int W  = 15;
    localparam int A  = 12;
    localparam int MC = 4;

    logic         clock;
    logic         rst;
    logic         flush;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic         idx_rsp_valid;
    logic [W-1:0] idx_rsp_data;
    logic         dec_ready;

    logic         instr_ready, idx_req_valid, dec_valid, dec_ext, int_inhibit, illegal;
    logic [A-1:0] idx_req_addr;
    logic [W-1:0] dec_word;

    logic         b_instr_ready, b_idx_req_valid, b_dec_valid, b_dec_ext, b_int_inhibit, b_illegal;
    logic [A-1:0] b_idx_req_addr;
    logic [W-1:0] b_dec_word;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (transaction level)
    bit           m_ext;
    logic [W-1:0] m_acc;
    int           m_chain;
    bit           m_pend;
    logic [A-1:0] m_addr;
    bit           m_ill;
    logic [W:0]   exp_q[$];

    agc_prefix_sequencer #(.WORD_W(W), .ADDR_W(A), .MAX_CHAIN(MC), .ONES_COMP(1), .EXTEND_CODE('o6)) u_dut (
        .clock(clock), .rst(rst), .flush(flush), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .idx_req_valid(idx_req_valid), .idx_req_addr(idx_req_addr),
        .idx_rsp_valid(idx_rsp_valid), .idx_rsp_data(idx_rsp_data), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_word(dec_word), .dec_ext(dec_ext),
        .int_inhibit(int_inhibit), .illegal(illegal)
    );

    agc_prefix_sequencer #(.WORD_W(W), .ADDR_W(A), .MAX_CHAIN(MC), .ONES_COMP(0), .EXTEND_CODE('o6)) u_dut_bin (
        .clock(clock), .rst(rst), .flush(flush), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(b_instr_ready), .idx_req_valid(b_idx_req_valid), .idx_req_addr(b_idx_req_addr),
        .idx_rsp_valid(idx_rsp_valid), .idx_rsp_data(idx_rsp_data), .dec_valid(b_dec_valid),
        .dec_ready(dec_ready), .dec_word(b_dec_word), .dec_ext(b_dec_ext),
        .int_inhibit(b_int_inhibit), .illegal(b_illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'o%0o required 'o%0o", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b, input bit ones);
        int s;
        s = int'(a) + int'(b);
        if (s >= (1 << W)) begin
            s = ones ? (s - (1 << W) + 1) : (s - (1 << W));
        end
        return W'(s);
    endfunction

    task automatic model_clear();
        m_ext   = 0;
        m_acc   = '0;
        m_chain = 0;
        m_pend  = 0;
        m_addr  = '0;
        m_ill   = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, check registered outputs against the model, advance the model.
    task automatic step(input bit iv, input logic [W-1:0] w, input bit dr, input bit fl,
                        input bit rv, input logic [W-1:0] rd);
        logic [W-1:0] e;
        logic [W:0]   item;
        bit           rdy;
        bit           ill_n;
        instr_valid   = iv;
        instr         = w;
        dec_ready     = dr;
        flush         = fl;
        idx_rsp_valid = rv;
        idx_rsp_data  = rd;
        #1;
        rdy = !m_pend && (exp_q.size() == 0 || dr) && !fl;
        check("int_inhibit", int_inhibit, m_ext || (m_chain != 0) || m_pend);
        check("dec_valid", dec_valid, exp_q.size() != 0);
        check("idx_req_valid", idx_req_valid, m_pend);
        if (m_pend) check("idx_req_addr", idx_req_addr, m_addr);
        check("illegal", illegal, m_ill);
        check("instr_ready", instr_ready, rdy);
        if (exp_q.size() != 0 && dr) begin
            item = exp_q.pop_front();
            check("dec_word", dec_word, item[W-1:0]);
            check("dec_ext", dec_ext, item[W]);
        end
        ill_n = 0;
        if (fl) begin
            model_clear();
        end else if (m_pend) begin
            if (rv) begin
                m_acc  = rd;
                m_pend = 0;
            end
        end else if (iv && rdy) begin
            e = madd(m_acc, w, 1'b1);
            if (e == W'('o6)) begin
                if (!m_ext) m_acc = '0;
                m_ext = 1;
            end else if (e[W-1:W-3] == 3'o5 && (m_ext || e[A-1:A-2] == 2'b00)) begin
                if (m_chain < MC) begin
                    m_chain++;
                    m_pend = 1;
                    m_addr = e[A-1:0];
                end else begin
                    ill_n   = 1;
                    m_ext   = 0;
                    m_acc   = '0;
                    m_chain = 0;
                end
            end else begin
                exp_q.push_back({m_ext, e});
                m_ext   = 0;
                m_acc   = '0;
                m_chain = 0;
            end
        end
        m_ill = ill_n;
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; instr_valid = 0; instr = '0;
        idx_rsp_valid = 0; idx_rsp_data = '0; dec_ready = 0;
        @(negedge clock);
        @(negedge clock);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_idx_req_valid", idx_req_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_int_inhibit", int_inhibit, 0);
        check("rst_dec_word", dec_word, 0);
        check("rst_idx_req_addr", idx_req_addr, 0);
        rst = 0;
        model_clear();
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] rd;
        do_reset();

        // Plain word
        step(1, 15'o30100, 0, 0, 0, 0);
        check("t1_dec_valid", dec_valid, 1);
        check("t1_dec_word", dec_word, 15'o30100);
        check("t1_dec_ext", dec_ext, 0);
        check("t1_inhibit", int_inhibit, 0);
        step(0, 0, 1, 0, 0, 0);

        // EXTEND then plain
        step(1, 15'o00006, 1, 0, 0, 0);
        check("t2_inhibit", int_inhibit, 1);
        step(1, 15'o10005, 1, 0, 0, 0);
        check("t2_dec_word", dec_word, 15'o10005);
        check("t2_dec_ext", dec_ext, 1);
        check("t2_ext_clear", int_inhibit, 0);
        step(0, 0, 1, 0, 0, 0);

        // INDEX with held address
        step(1, 15'o50020, 1, 0, 0, 0);
        check("t3_req", idx_req_valid, 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("t3_addr_held", idx_req_addr, 12'o0020);
        step(0, 0, 1, 0, 1, 15'o00005);
        step(1, 15'o30100, 1, 0, 0, 0);
        check("t3_dec_word", dec_word, 15'o30105);
        step(0, 0, 1, 0, 0, 0);

        // End-around carry vs binary wrap
        step(1, 15'o50000, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 15'o77776);
        step(1, 15'o00002, 1, 0, 0, 0);
        check("t4_ones_comp", dec_word, 15'o00001);
        check("t4_binary", b_dec_word, 15'o00000);
        step(0, 0, 1, 0, 0, 0);

        // Chain overflow
        step(1, 15'o00006, 1, 0, 0, 0);
        for (int i = 0; i < MC; i++) begin
            step(1, 15'o50010, 1, 0, 0, 0);
            step(0, 0, 1, 0, 1, 15'o00001);
        end
        step(1, 15'o50010, 1, 0, 0, 0);
        check("t5_illegal", illegal, 1);
        step(0, 0, 1, 0, 0, 0);
        check("t5_illegal_pulse", illegal, 0);
        step(1, 15'o30100, 1, 0, 0, 0);
        check("t5_dec_word", dec_word, 15'o30100);
        check("t5_dec_ext", dec_ext, 0);
        step(0, 0, 1, 0, 0, 0);

        // Flush in WAIT_IDX, late response, then backpressure
        step(1, 15'o00006, 1, 0, 0, 0);
        step(1, 15'o50020, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        check("t6_req_drop", idx_req_valid, 0);
        step(0, 0, 1, 0, 1, 15'o00777);
        step(1, 15'o30100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 15'o30200, 0, 0, 0, 0);
            check("t6_hold_word", dec_word, 15'o30100);
            check("t6_hold_ext", dec_ext, 0);
            check("t6_hold_ready", instr_ready, 0);
        end
        step(0, 0, 1, 0, 0, 0);

        // Reset while an operand is outstanding
        step(1, 15'o50020, 1, 0, 0, 0);
        do_reset();
        check("t7_req_after_rst", idx_req_valid, 0);
        check("t7_inhibit_after_rst", int_inhibit, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 4)
                0:       w = 15'o00006;
                1:       w = {3'o5, 2'b00, 10'($urandom)};
                2:       w = {3'o5, 12'($urandom)};
                default: w = 15'($urandom);
            endcase
            rd = ($urandom % 2 == 0) ? 15'($urandom % 8) : 15'($urandom);
            step(($urandom % 4) != 0, w, ($urandom % 4) != 0, ($urandom % 32) == 0,
                 ($urandom % 3) == 0, rd);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
